// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
// Module   : execute_unit
// Purpose  : TinyRisc execute stage. One operand packet per valid/ready
//            handshake; single-cycle ALU ops, branch resolution, CMP flags
//            and an iterative restoring signed divider for DIV/MOD.
// Revision : 1.0 - initial release
// ============================================================================
module execute_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            is_beq,
  input  logic            is_bgt,
  input  logic            is_ubranch,
  input  logic            is_ret,
  input  logic [XLEN-1:0] branch_target_in,
  input  logic [3:0]      rd_in,
  input  logic            wb_en_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_pc,
  output logic [3:0]      rd_out,
  output logic            wb_en_out,
  output logic            flag_e,
  output logic            flag_gt,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int SH_W  = $clog2(XLEN);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_LSL = 4'd10;
  localparam logic [3:0] OP_LSR = 4'd11;
  localparam logic [3:0] OP_ASR = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_mod_q, is_mod_d;
  logic             dvz_q, dvz_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             branch_taken_q, branch_taken_d;
  logic [XLEN-1:0]  branch_pc_q, branch_pc_d;
  logic [3:0]       rd_q, rd_d;
  logic             wb_en_q, wb_en_d;
  logic             flag_e_q, flag_e_d;
  logic             flag_gt_q, flag_gt_d;

  logic             fire;
  logic             is_div_op;
  logic [XLEN-1:0]  alu_res;
  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    trial;
  logic [XLEN-1:0]  quo_fix;
  logic [XLEN-1:0]  rem_fix;

  // New packets only while the divider is idle and the output slot is free
  // or being drained this cycle.
  assign in_ready  = (state_q == ST_IDLE) & (~out_valid_q | out_ready);
  assign fire      = in_valid & in_ready;
  assign is_div_op = (alu_op == OP_DIV) | (alu_op == OP_MOD);

  // Single-cycle ALU result; CMP, DIV/MOD and reserved codes yield 0 here.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_MUL:  alu_res = op1 * op2;
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_NOT:  alu_res = ~op2;
      OP_MOV:  alu_res = op2;
      OP_LSL:  alu_res = op1 << op2[SH_W-1:0];
      OP_LSR:  alu_res = op1 >> op2[SH_W-1:0];
      OP_ASR:  alu_res = $unsigned($signed(op1) >>> op2[SH_W-1:0]);
      default: alu_res = '0;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only if it did not go negative.
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    trial   = rem_sh - {1'b0, dvsr_q};
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
  end

  // Next-state logic for the divider FSM and the registered output packet.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    dvsr_d         = dvsr_q;
    neg_quo_d      = neg_quo_q;
    neg_rem_d      = neg_rem_q;
    is_mod_d       = is_mod_q;
    dvz_d          = dvz_q;
    out_valid_d    = out_valid_q;
    result_d       = result_q;
    branch_taken_d = branch_taken_q;
    branch_pc_d    = branch_pc_q;
    rd_d           = rd_q;
    wb_en_d        = wb_en_q;
    flag_e_d       = flag_e_q;
    flag_gt_d      = flag_gt_q;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          rd_d    = rd_in;
          wb_en_d = wb_en_in;
          if (is_div_op) begin
            // Divide on magnitudes; signs are reapplied when the result loads.
            state_d        = ST_DIV;
            count_d        = '0;
            rem_d          = '0;
            quo_d          = op1[XLEN-1] ? -op1 : op1;
            dvsr_d         = op2[XLEN-1] ? -op2 : op2;
            neg_quo_d      = op1[XLEN-1] ^ op2[XLEN-1];
            neg_rem_d      = op1[XLEN-1];
            is_mod_d       = (alu_op == OP_MOD);
            dvz_d          = (op2 == '0);
            out_valid_d    = 1'b0;
            branch_taken_d = 1'b0;
            branch_pc_d    = '0;
          end else begin
            out_valid_d    = 1'b1;
            result_d       = alu_res;
            branch_taken_d = is_ubranch | (is_beq & flag_e_q) | (is_bgt & flag_gt_q);
            branch_pc_d    = is_ret ? op1 : branch_target_in;
            if (alu_op == OP_CMP) begin
              flag_e_d  = (op1 == op2);
              flag_gt_d = ($signed(op1) > $signed(op2));
            end
          end
        end
      end
      ST_DIV: begin
        quo_d   = {quo_q[XLEN-2:0], ~trial[XLEN]};
        rem_d   = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(XLEN - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A zero divisor leaves |op1| in the remainder, so MOD needs no
        // special case; DIV by zero is forced to all ones.
        if (is_mod_q) begin
          result_d = rem_fix;
        end else if (dvz_q) begin
          result_d = '1;
        end else begin
          result_d = quo_fix;
        end
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvsr_q         <= '0;
      neg_quo_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
      is_mod_q       <= 1'b0;
      dvz_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      result_q       <= '0;
      branch_taken_q <= 1'b0;
      branch_pc_q    <= '0;
      rd_q           <= '0;
      wb_en_q        <= 1'b0;
      flag_e_q       <= 1'b0;
      flag_gt_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      dvsr_q         <= dvsr_d;
      neg_quo_q      <= neg_quo_d;
      neg_rem_q      <= neg_rem_d;
      is_mod_q       <= is_mod_d;
      dvz_q          <= dvz_d;
      out_valid_q    <= out_valid_d;
      result_q       <= result_d;
      branch_taken_q <= branch_taken_d;
      branch_pc_q    <= branch_pc_d;
      rd_q           <= rd_d;
      wb_en_q        <= wb_en_d;
      flag_e_q       <= flag_e_d;
      flag_gt_q      <= flag_gt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign branch_taken = branch_taken_q;
  assign branch_pc    = branch_pc_q;
  assign rd_out       = rd_q;
  assign wb_en_out    = wb_en_q;
  assign flag_e       = flag_e_q;
  assign flag_gt      = flag_gt_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_unit
// Purpose  : Self-checking bench for execute_unit: directed scenarios plus a
//            randomized run scored against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_unit;

  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      alu_op = '0;
  logic [XLEN-1:0] op1 = '0;
  logic [XLEN-1:0] op2 = '0;
  logic            is_beq = 1'b0;
  logic            is_bgt = 1'b0;
  logic            is_ubranch = 1'b0;
  logic            is_ret = 1'b0;
  logic [XLEN-1:0] branch_target_in = '0;
  logic [3:0]      rd_in = '0;
  logic            wb_en_in = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic [XLEN-1:0] branch_pc;
  logic [3:0]      rd_out;
  logic            wb_en_out;
  logic            flag_e;
  logic            flag_gt;
  logic            busy;

  typedef struct packed {
    logic [31:0] res;
    logic        bt;
    logic [31:0] bpc;
    logic [3:0]  rd;
    logic        wb;
    logic        fe;
    logic        fg;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_fe = 1'b0;
  logic m_fg = 1'b0;

  always #5 clock = ~clock;

  execute_unit #(.XLEN(XLEN)) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .alu_op           (alu_op),
    .op1              (op1),
    .op2              (op2),
    .is_beq           (is_beq),
    .is_bgt           (is_bgt),
    .is_ubranch       (is_ubranch),
    .is_ret           (is_ret),
    .branch_target_in (branch_target_in),
    .rd_in            (rd_in),
    .wb_en_in         (wb_en_in),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .branch_taken     (branch_taken),
    .branch_pc        (branch_pc),
    .rd_out           (rd_out),
    .wb_en_out        (wb_en_out),
    .flag_e           (flag_e),
    .flag_gt          (flag_gt),
    .busy             (busy)
  );

  // Reference model: architectural result of one packet, from plain arithmetic.
  task automatic model_pkt(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic beq, input logic bgt, input logic ub, input logic ret,
                           input logic [31:0] tgt, input logic [3:0] rd, input logic wb,
                           output exp_t e);
    longint sa;
    longint sb;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a * b;
      4'd3:  if (b == 0) r = 32'hFFFF_FFFF; else r = 32'(sa / sb);
      4'd4:  if (b == 0) r = a; else r = 32'(sa % sb);
      4'd6:  r = a & b;
      4'd7:  r = a | b;
      4'd8:  r = ~b;
      4'd9:  r = b;
      4'd10: r = a << b[4:0];
      4'd11: r = a >> b[4:0];
      4'd12: r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
    e.res = r;
    e.rd  = rd;
    e.wb  = wb;
    if (op == 4'd3 || op == 4'd4) begin
      e.bt  = 1'b0;
      e.bpc = '0;
    end else begin
      e.bt  = ub | (beq & m_fe) | (bgt & m_fg);
      e.bpc = ret ? a : tgt;
    end
    if (op == 4'd5) begin
      m_fe = (a == b);
      m_fg = (sa > sb);
    end
    e.fe = m_fe;
    e.fg = m_fg;
  endtask

  // Present a packet at a falling edge and return at the falling edge after it fires.
  task automatic drive_pkt(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic beq, input logic bgt, input logic ub, input logic ret,
                           input logic [31:0] tgt, input logic [3:0] rd, input logic wb);
    int guard;
    guard = 0;
    alu_op = op; op1 = a; op2 = b;
    is_beq = beq; is_bgt = bgt; is_ubranch = ub; is_ret = ret;
    branch_target_in = tgt; rd_in = rd; wb_en_in = wb;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clock); #1;
      guard++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL drive_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
    end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, reporting the latency and whether the block looked idle meanwhile.
  task automatic wait_out(output int lat, output bit leak);
    lat  = 0;
    leak = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready || !busy) leak = 1'b1;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_fe = 1'b0; m_fg = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, branch_taken, wb_en_out, flag_e, flag_gt, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid/bt/wb/fe/fg/busy=%b, required 000000",
               {out_valid, branch_taken, wb_en_out, flag_e, flag_gt, busy});
    end
    n_checks++;
    if ({result, branch_pc, rd_out} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_data: result=%h pc=%h rd=%h, required zeros", result, branch_pc, rd_out);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    drive_pkt(4'd0, 32'd7, 32'd5, 0, 0, 0, 0, 32'h0, 4'd3, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'd12 || rd_out !== 4'd3 || wb_en_out !== 1'b1) begin
      n_fail++;
      $display("FAIL add: valid=%b result=%h rd=%h wb=%b, required 1 0000000c 3 1",
               out_valid, result, rd_out, wb_en_out);
    end
    drive_pkt(4'd1, 32'd5, 32'd7, 0, 0, 0, 0, 32'h0, 4'd4, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL sub: valid=%b result=%h, required 1 fffffffe", out_valid, result);
    end
    @(negedge clock);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_cmp_branch();
    out_ready = 1'b1;
    drive_pkt(4'd5, 32'd3, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0, 4'd0, 1'b0);
    n_checks++;
    if (flag_e !== 1'b0 || flag_gt !== 1'b1 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL cmp_flags: fe=%b fg=%b result=%h, required 0 1 0", flag_e, flag_gt, result);
    end
    drive_pkt(4'd9, 32'h0, 32'h0, 0, 1, 0, 0, 32'h40, 4'd0, 1'b0);
    n_checks++;
    if (branch_taken !== 1'b1 || branch_pc !== 32'h40) begin
      n_fail++;
      $display("FAIL bgt_taken: bt=%b pc=%h, required 1 00000040", branch_taken, branch_pc);
    end
    drive_pkt(4'd9, 32'h0, 32'h0, 1, 0, 0, 0, 32'h80, 4'd0, 1'b0);
    n_checks++;
    if (branch_taken !== 1'b0 || flag_gt !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_not_taken: bt=%b fg=%b, required 0 1", branch_taken, flag_gt);
    end
    drive_pkt(4'd0, 32'h1234, 32'h0, 0, 0, 1, 1, 32'h80, 4'd0, 1'b0);
    n_checks++;
    if (branch_taken !== 1'b1 || branch_pc !== 32'h1234) begin
      n_fail++;
      $display("FAIL ret: bt=%b pc=%h, required 1 00001234", branch_taken, branch_pc);
    end
    @(negedge clock);
  endtask

  task automatic test_div();
    int lat;
    bit leak;
    logic [31:0] exp_v [5];
    logic [3:0]  ops   [5];
    logic [31:0] a_v   [5];
    logic [31:0] b_v   [5];
    out_ready = 1'b1;
    ops[0] = 4'd3; a_v[0] = 32'hFFFF_FFF9; b_v[0] = 32'd2;          exp_v[0] = 32'hFFFF_FFFD;
    ops[1] = 4'd4; a_v[1] = 32'hFFFF_FFF9; b_v[1] = 32'd2;          exp_v[1] = 32'hFFFF_FFFF;
    ops[2] = 4'd3; a_v[2] = 32'd9;         b_v[2] = 32'd0;          exp_v[2] = 32'hFFFF_FFFF;
    ops[3] = 4'd4; a_v[3] = 32'd9;         b_v[3] = 32'd0;          exp_v[3] = 32'd9;
    ops[4] = 4'd3; a_v[4] = 32'h8000_0000; b_v[4] = 32'hFFFF_FFFF;  exp_v[4] = 32'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      drive_pkt(ops[i], a_v[i], b_v[i], 0, 0, 1, 0, 32'h44, 4'(i + 8), 1'b1);
      wait_out(lat, leak);
      n_checks++;
      if (result !== exp_v[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL div_result[%0d]: result=%h valid=%b, required %h 1", i, result, out_valid, exp_v[i]);
      end
      n_checks++;
      if (lat != 33 || leak) begin
        n_fail++;
        $display("FAIL div_timing[%0d]: latency=%0d ready_or_idle_seen=%0b, required 33 0", i, lat, leak);
      end
      n_checks++;
      if (branch_taken !== 1'b0 || branch_pc !== 32'h0 || rd_out !== 4'(i + 8)) begin
        n_fail++;
        $display("FAIL div_side[%0d]: bt=%b pc=%h rd=%h, required 0 0 %h", i, branch_taken, branch_pc, rd_out, 4'(i + 8));
      end
      @(negedge clock);
    end
  endtask

  task automatic test_backpressure();
    bit bad;
    bad = 1'b0;
    out_ready = 1'b0;
    drive_pkt(4'd0, 32'd7, 32'd5, 0, 0, 0, 0, 32'h0, 4'd1, 1'b1);
    alu_op = 4'd0; op1 = 32'd1; op2 = 32'd2; rd_in = 4'd2; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (out_valid !== 1'b1 || result !== 32'd12 || in_ready !== 1'b0 || rd_out !== 4'd1) bad = 1'b1;
      @(negedge clock);
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL stall_hold: valid=%b result=%h in_ready=%b rd=%h, required 1 0000000c 0 1",
               out_valid, result, in_ready, rd_out);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready: in_ready=%b, required 1", in_ready);
    end
    @(negedge clock);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'd3 || rd_out !== 4'd2) begin
      n_fail++;
      $display("FAIL after_stall: valid=%b result=%h rd=%h, required 1 00000003 2", out_valid, result, rd_out);
    end
    @(negedge clock);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_duplicate: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    out_ready = 1'b1;
    drive_pkt(4'd5, 32'd5, 32'd5, 0, 0, 0, 0, 32'h0, 4'd0, 1'b0);
    n_checks++;
    if (flag_e !== 1'b1) begin
      n_fail++;
      $display("FAIL cmp_equal: fe=%b, required 1", flag_e);
    end
    @(negedge clock);
    drive_pkt(4'd3, 32'd100, 32'd3, 0, 0, 0, 0, 32'h0, 4'd5, 1'b1);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_fe = 1'b0; m_fg = 1'b0;
    n_checks++;
    if ({out_valid, busy, flag_e, flag_gt} !== 4'b0) begin
      n_fail++;
      $display("FAIL abort: valid/busy/fe/fg=%b, required 0000", {out_valid, busy, flag_e, flag_gt});
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL aborted_output: out_valid seen=1, required 0");
    end
    drive_pkt(4'd0, 32'd1, 32'd1, 0, 0, 0, 0, 32'h0, 4'd6, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'd2) begin
      n_fail++;
      $display("FAIL add_after_abort: valid=%b result=%h, required 1 00000002", out_valid, result);
    end
    @(negedge clock);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random(input int npkts);
    exp_t q[$];
    exp_t e;
    exp_t g;
    int   sent;
    int   got;
    int   cyc;
    bit   fired;
    sent = 0; got = 0; cyc = 0; fired = 1'b0;
    do_reset();
    while (got < npkts && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      if (fired) in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < npkts && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 99) < 12) alu_op = $urandom_range(0, 1) ? 4'd3 : 4'd4;
        else alu_op = 4'($urandom_range(0, 15));
        op1 = pick_val(); op2 = pick_val();
        is_beq = $urandom_range(0, 1); is_bgt = $urandom_range(0, 1);
        is_ubranch = ($urandom_range(0, 3) == 0); is_ret = $urandom_range(0, 1);
        branch_target_in = $urandom; rd_in = 4'($urandom_range(0, 15)); wb_en_in = $urandom_range(0, 1);
        in_valid = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: output with result=%h, required none pending", result);
        end else begin
          e = q.pop_front();
          got++;
          g = '{result, branch_taken, branch_pc, rd_out, wb_en_out, flag_e, flag_gt};
          if (g.res !== e.res) begin
            n_fail++;
            $display("FAIL rand_result[%0d]: got %h, required %h", got, g.res, e.res);
          end
          n_checks++;
          if (g !== e) begin
            n_fail++;
            $display("FAIL rand_packet[%0d]: got %h, required %h", got, g, e);
          end
        end
      end
      fired = 1'b0;
      if (in_valid && in_ready) begin
        model_pkt(alu_op, op1, op2, is_beq, is_bgt, is_ubranch, is_ret, branch_target_in, rd_in, wb_en_in, e);
        q.push_back(e);
        sent++;
        fired = 1'b1;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != npkts || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_complete: received=%0d pending=%0d, required %0d 0", got, q.size(), npkts);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_cmp_branch();
    test_div();
    test_backpressure();
    test_reset_mid_div();
    test_random(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
